r5fp_cvt_sched: RTL and testbench

- Shares one fp-format-resize datapath (exponent widen E→E+1 and narrow E+1→E) between NREQ requesters.
- Requester selection is round-robin; ready/valid handshakes on both sides.
- The datapath is wrapped in a 2-stage stallable pipeline; each result carries the requester index back.
- Sits between FPU issue logic and the convert/compare units that work in the extended-exponent internal format.

---
 rtl/r5fp_cvt_sched_pkg.sv | 28 ++
 rtl/r5fp_rr_arbiter.sv | 42 ++++
 rtl/r5fp_cvt_sched.sv | 166 ++++++++++++++++
 tb/tb_r5fp_cvt_sched.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/r5fp_cvt_sched_pkg.sv
// Shared constants and helpers for the fp exponent-resize scheduler.
// Narrow format: {sign, exp[EXP_W], sig[SIG_W]}; wide format uses EXP_W+1 exponent bits.
package r5fp_cvt_sched_pkg;

   localparam int unsigned DEF_SIG_W = 10;
   localparam int unsigned DEF_EXP_W = 5;
   localparam int unsigned DEF_NARROW_W = DEF_SIG_W + DEF_EXP_W + 1;
   localparam int unsigned DEF_WIDE_W = DEF_SIG_W + DEF_EXP_W + 2;

   localparam logic OP_WIDEN  = 1'b0;
   localparam logic OP_NARROW = 1'b1;

   // Wide bias minus narrow bias: (2^EXP_W - 1) - (2^(EXP_W-1) - 1)
   function automatic int unsigned biasDiff(input int unsigned expW);
      return 32'd1 << (expW - 1);
   endfunction

   function automatic int unsigned tagWidth(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned DEF_BIAS_DIFF = biasDiff(DEF_EXP_W);

   // Wide exponents that land in the narrow denormal range
   localparam int unsigned EXP_DENORMAL_MIN = 1;
   localparam int unsigned EXP_DENORMAL_MAX = DEF_BIAS_DIFF;

endpackage

// File: rtl/r5fp_rr_arbiter.sv
// Round-robin grant among NREQ requesters; pointer moves past the winner on advance.
module r5fp_rr_arbiter #(
   parameter int unsigned NREQ  = 2,
   parameter int unsigned TAG_W = 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [NREQ-1:0]  req,
   input  logic             advance,
   output logic [TAG_W-1:0] grant,
   output logic [NREQ-1:0]  onehot
);

   logic [TAG_W-1:0] ptr;
   logic             found;

   // Search from ptr upward with wrap; first requester wins
   always_comb begin
      grant  = '0;
      onehot = '0;
      found  = 1'b0;
      for (int k = 0; k < int'(NREQ); k++) begin
         for (int i = 0; i < int'(NREQ); i++) begin
            if (!found && req[i] &&
                (i == ((int'(ptr) + k) % int'(NREQ)))) begin
               found     = 1'b1;
               grant     = TAG_W'(i);
               onehot[i] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (grant == TAG_W'(NREQ - 1)) ? '0 : grant + TAG_W'(1);
      end
   end

endmodule

// File: rtl/r5fp_cvt_sched.sv
// Shares one widen/narrow exponent-resize datapath between NREQ requesters
// through a round-robin arbiter and a 2-stage stallable pipeline.
module r5fp_cvt_sched
   import r5fp_cvt_sched_pkg::*;
#(
   parameter int unsigned SIG_W = DEF_SIG_W,
   parameter int unsigned EXP_W = DEF_EXP_W,
   parameter int unsigned NREQ  = 2
) (
   input  logic                                   clk,
   input  logic                                   rstn,
   input  logic [NREQ-1:0]                        req_valid,
   output logic [NREQ-1:0]                        req_ready,
   input  logic [NREQ-1:0]                        req_op,
   input  logic [NREQ*(SIG_W+EXP_W+2)-1:0]        req_a,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [tagWidth(NREQ)-1:0]              out_tag,
   output logic                                   out_op,
   output logic [SIG_W+EXP_W+1:0]                 out_z
);

   localparam int unsigned W         = SIG_W + EXP_W + 2;
   localparam int unsigned EW        = EXP_W + 1;
   localparam int unsigned TAG_W     = tagWidth(NREQ);
   localparam int unsigned BIAS_DIFF = biasDiff(EXP_W);
   localparam int unsigned DEN_MIN   = EXP_DENORMAL_MIN;
   localparam int unsigned DEN_MAX   = BIAS_DIFF;

   // Narrow -> wide; operand bit W-1 is ignored
   function automatic logic [W-1:0] expInc(input logic [W-1:0] a);
      logic [EXP_W-1:0] e;
      logic [SIG_W-1:0] s;
      logic [W-1:0]     z;
      int unsigned      lz;
      logic             hit;
      e = a[W-3:SIG_W];
      s = a[SIG_W-1:0];
      z = '0;
      z[W-1] = a[W-2];
      lz  = 0;
      hit = 1'b0;
      for (int i = SIG_W - 1; i >= 0; i--) begin
         if (!hit) begin
            if (s[i]) hit = 1'b1;
            else      lz  = lz + 1;
         end
      end
      if (e == '0 && s == '0) begin
         z[W-2:0] = '0;
      end else if (e == '0) begin
         z[W-2:SIG_W]   = EW'(BIAS_DIFF - lz);
         z[SIG_W-1:0]   = s << (lz + 1);
      end else if (e == '1) begin
         z[W-2:SIG_W]   = '1;
         z[SIG_W-1:0]   = s;
      end else begin
         z[W-2:SIG_W]   = EW'(e) + EW'(BIAS_DIFF);
         z[SIG_W-1:0]   = s;
      end
      return z;
   endfunction

   // Wide -> narrow; result zero-extended to W bits
   function automatic logic [W-1:0] expDec(input logic [W-1:0] a);
      logic [EW-1:0]    e;
      logic [SIG_W-1:0] s;
      logic [SIG_W:0]   mant;
      logic [W-1:0]     z;
      int unsigned      shAmt;
      e = a[W-2:SIG_W];
      s = a[SIG_W-1:0];
      mant = {1'b1, s};
      shAmt = 1 + DEN_MAX - 32'(e);
      z = '0;
      z[W-2] = a[W-1];
      if (e == '0) begin
         z[W-3:0] = '0;
      end else if (e == '1) begin
         z[W-3:SIG_W] = '1;
         z[SIG_W-1:0] = s;
      end else if (e >= EW'(DEN_MIN) && e <= EW'(DEN_MAX)) begin
         z[W-3:SIG_W] = '0;
         z[SIG_W-1:0] = SIG_W'(mant >> shAmt);
      end else begin
         z[W-3:SIG_W] = EXP_W'(e - EW'(BIAS_DIFF));
         z[SIG_W-1:0] = s;
      end
      return z;
   endfunction

   logic             stage1En, stage2En, anyReq, accept;
   logic [TAG_W-1:0] grant;
   logic [NREQ-1:0]  onehot;
   logic             selOp;
   logic [W-1:0]     selA, cvtZ;

   logic             s1Valid, s1Op;
   logic [TAG_W-1:0] s1Tag;
   logic [W-1:0]     s1A;
   logic             s2Valid, s2Op;
   logic [TAG_W-1:0] s2Tag;
   logic [W-1:0]     s2Z;

   assign stage2En  = !s2Valid | out_ready;
   assign stage1En  = !s1Valid | stage2En;
   assign anyReq    = |req_valid;
   assign accept    = anyReq & stage1En & rstn;
   assign req_ready = onehot & {NREQ{stage1En & rstn}};

   r5fp_rr_arbiter #(
      .NREQ  (NREQ),
      .TAG_W (TAG_W)
   ) u_arb (
      .clk     (clk),
      .rstn    (rstn),
      .req     (req_valid),
      .advance (accept),
      .grant   (grant),
      .onehot  (onehot)
   );

   // Operand mux driven by the one-hot grant
   always_comb begin
      selOp = OP_WIDEN;
      selA  = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (onehot[i]) begin
            selOp = req_op[i];
            selA  = req_a[i*W +: W];
         end
      end
   end

   assign cvtZ = (s1Op == OP_NARROW) ? expDec(s1A) : expInc(s1A);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         s1Valid <= 1'b0;
         s2Valid <= 1'b0;
      end else begin
         if (stage1En) s1Valid <= anyReq;
         if (stage2En) s2Valid <= s1Valid;
      end
   end

   // Payload registers carry no reset; qualified by the valid bits
   always_ff @(posedge clk) begin
      if (stage1En) begin
         s1Op  <= selOp;
         s1Tag <= grant;
         s1A   <= selA;
      end
      if (stage2En) begin
         s2Op  <= s1Op;
         s2Tag <= s1Tag;
         s2Z   <= cvtZ;
      end
   end

   assign out_valid = s2Valid;
   assign out_tag   = s2Tag;
   assign out_op    = s2Op;
   assign out_z     = s2Z;

endmodule

// File: tb/tb_r5fp_cvt_sched.sv
// Directed bench for r5fp_cvt_sched: conversions, round-robin fairness, stall and reset.
module tb_r5fp_cvt_sched;

   localparam int unsigned SIG_W = 10;
   localparam int unsigned EXP_W = 5;
   localparam int unsigned NREQ  = 2;
   localparam int unsigned W     = SIG_W + EXP_W + 2;
   localparam int unsigned TAG_W = 1;

   logic                 clk = 1'b0;
   logic                 rstn;
   logic [NREQ-1:0]      req_valid, req_ready, req_op;
   logic [NREQ*W-1:0]    req_a;
   logic                 out_valid, out_ready, out_op;
   logic [TAG_W-1:0]     out_tag;
   logic [W-1:0]         out_z;

   int nVectors = 0;
   int nMiscompares = 0;

   always #5 clk = ~clk;

   r5fp_cvt_sched #(
      .SIG_W (SIG_W),
      .EXP_W (EXP_W),
      .NREQ  (NREQ)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_tag   (out_tag),
      .out_op    (out_op),
      .out_z     (out_z)
   );

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nVectors++;
      if (got !== exp) begin
         nMiscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setReq(input int idx, input logic op, input logic [W-1:0] a);
      req_op[idx]        = op;
      req_a[idx*W +: W]  = a;
      req_valid[idx]     = 1'b1;
   endtask

   task automatic doReset();
      req_valid = '0;
      rstn = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
   endtask

   // Single isolated transfer: accept at edge N, result visible after edge N+1
   task automatic runOne(input string tag, input int idx, input logic op,
                         input logic [W-1:0] a, input logic [W-1:0] expZ);
      out_ready = 1'b1;
      setReq(idx, op, a);
      #1;
      checkVal({tag, ".rdy"}, 32'(req_ready), 32'd1 << idx);
      tick();
      req_valid = '0;
      checkVal({tag, ".v0"}, 32'(out_valid), 32'd0);
      tick();
      checkVal({tag, ".v1"}, 32'(out_valid), 32'd1);
      checkVal({tag, ".z"}, 32'(out_z), 32'(expZ));
      checkVal({tag, ".tag"}, 32'(out_tag), 32'(idx));
      checkVal({tag, ".op"}, 32'(out_op), 32'(op));
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] held;
      logic         haveZ;
      int           nAcc;
      int           nGot;
      logic [31:0]  gotTag [4];
      logic [31:0]  gotZ [4];

      rstn = 1'b0;
      req_valid = '0;
      req_op = '0;
      req_a = '0;
      out_ready = 1'b1;

      // Reset with requests pending: no grant, pipeline empty
      req_valid = 2'b11;
      tick();
      #1;
      checkVal("reset.rdy", 32'(req_ready), 32'd0);
      tick();
      checkVal("reset.ov", 32'(out_valid), 32'd0);
      req_valid = '0;
      rstn = 1'b1;
      tick();

      runOne("widen_one",    0, 1'b0, 17'h03C00, 17'h07C00);
      runOne("narrow_one",   1, 1'b1, 17'h07C00, 17'h03C00);
      runOne("widen_inf",    0, 1'b0, 17'h07C00, 17'h0FC00);
      runOne("widen_den1",   0, 1'b0, 17'h00001, 17'h01C00);
      runOne("widen_negz",   1, 1'b0, 17'h08000, 17'h10000);
      runOne("widen_msbign", 0, 1'b0, 17'h13C00, 17'h07C00);
      runOne("widen_nan",    1, 1'b0, 17'h07E01, 17'h0FE01);
      runOne("widen_den200", 0, 1'b0, 17'h00200, 17'h04000);
      runOne("widen_den155", 1, 1'b0, 17'h00155, 17'h03D54);
      runOne("narrow_den",   0, 1'b1, 17'h03D54, 17'h00155);
      runOne("narrow_dmax",  1, 1'b1, 17'h04000, 17'h00200);
      runOne("narrow_negz",  0, 1'b1, 17'h10000, 17'h08000);
      runOne("narrow_inf",   1, 1'b1, 17'h0FC00, 17'h07C00);
      runOne("narrow_nan",   0, 1'b1, 17'h0FE01, 17'h07E01);
      runOne("narrow_e17",   1, 1'b1, 17'h047FF, 17'h007FF);

      // Fairness: both requesters always valid, full-rate flow
      doReset();
      out_ready = 1'b1;
      setReq(0, 1'b0, 17'h03C00);
      setReq(1, 1'b1, 17'h07C00);
      for (int k = 0; k < 8; k++) begin
         #1;
         checkVal($sformatf("fair.rdy%0d", k), 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
         if (k >= 2) begin
            checkVal($sformatf("fair.ov%0d", k), 32'(out_valid), 32'd1);
            checkVal($sformatf("fair.tag%0d", k), 32'(out_tag), 32'(k % 2));
            checkVal($sformatf("fair.z%0d", k), 32'(out_z),
                     (k % 2 == 0) ? 32'h07C00 : 32'h03C00);
         end
         tick();
      end
      req_valid = '0;
      tick();
      tick();

      // Backpressure: downstream stalled for 5 cycles
      doReset();
      out_ready = 1'b0;
      setReq(0, 1'b0, 17'h03C00);
      setReq(1, 1'b1, 17'h07C00);
      nAcc = 0;
      haveZ = 1'b0;
      held = '0;
      for (int k = 0; k < 5; k++) begin
         #1;
         if (|(req_ready & req_valid)) nAcc++;
         if (out_valid) begin
            if (!haveZ) begin
               held = out_z;
               haveZ = 1'b1;
               checkVal("bp.first", 32'(out_z), 32'h07C00);
            end else begin
               checkVal($sformatf("bp.stable%0d", k), 32'(out_z), 32'(held));
            end
         end
         tick();
      end
      checkVal("bp.accepts", 32'(nAcc), 32'd2);
      checkVal("bp.held", 32'(haveZ), 32'd1);
      req_valid = '0;
      out_ready = 1'b1;
      nGot = 0;
      for (int k = 0; k < 6; k++) begin
         #1;
         if (out_valid) begin
            if (nGot < 4) begin
               gotTag[nGot] = 32'(out_tag);
               gotZ[nGot]   = 32'(out_z);
            end
            nGot++;
         end
         tick();
      end
      checkVal("bp.drained", 32'(nGot), 32'd2);
      checkVal("bp.tag0", gotTag[0], 32'd0);
      checkVal("bp.z0", gotZ[0], 32'h07C00);
      checkVal("bp.tag1", gotTag[1], 32'd1);
      checkVal("bp.z1", gotZ[1], 32'h03C00);

      // Reset with S1 and S2 both occupied
      doReset();
      out_ready = 1'b0;
      setReq(0, 1'b0, 17'h03C00);
      setReq(1, 1'b1, 17'h07C00);
      tick();
      tick();
      checkVal("mid.full", 32'(out_valid), 32'd1);
      rstn = 1'b0;
      #1;
      checkVal("mid.rdy_rst", 32'(req_ready), 32'd0);
      tick();
      rstn = 1'b1;
      checkVal("mid.ov", 32'(out_valid), 32'd0);
      #1;
      checkVal("mid.ptr0", 32'(req_ready), 32'd1);
      out_ready = 1'b1;
      tick();
      req_valid = '0;
      tick();
      checkVal("mid.res_v", 32'(out_valid), 32'd1);
      checkVal("mid.res_tag", 32'(out_tag), 32'd0);
      checkVal("mid.res_z", 32'(out_z), 32'h07C00);
      tick();
      checkVal("mid.no_stale", 32'(out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
